// File: rtl/ir_cmd_mapper_if.sv
// Bundle of IR-frame input, motor-command output and status-byte handshake
// signals shared between the IR command mapper and its neighbours.
interface ir_cmd_mapper_if;
    logic        frame_valid;
    logic [31:0] frame_data;
    logic        ir_repeat;
    logic [2:0]  cmd_idx;
    logic [7:0]  cmd_onehot;
    logic        timed_out;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;

    // master: frame source / UART side; slave: the mapper itself
    modport master (
        output frame_valid, frame_data, ir_repeat, tx_ready,
        input  cmd_idx, cmd_onehot, timed_out, tx_valid, tx_byte
    );

    modport slave (
        input  frame_valid, frame_data, ir_repeat, tx_ready,
        output cmd_idx, cmd_onehot, timed_out, tx_valid, tx_byte
    );
endinterface

// File: rtl/ir_cmd_mapper.sv
// Maps checked NEC IR frames onto a motor command index with repeat and dead-man
// handling, and reports status bytes over a valid/ready link.
module ir_cmd_mapper #(
    parameter int unsigned           NUM_CMDS         = 5,
    parameter logic [8*NUM_CMDS-1:0] KEY_MAP          = 40'h08_06_05_04_02,
    parameter int unsigned           TIMEOUT_CYCLES   = 5_000_000,
    parameter int unsigned           HEARTBEAT_CYCLES = 50_000_000
) (
    input logic            clk,
    input logic            rst,
    ir_cmd_mapper_if.slave bus
);

    if (NUM_CMDS < 1 || NUM_CMDS > 7 || TIMEOUT_CYCLES < 2 || HEARTBEAT_CYCLES < 1)
    begin : g_param_check
        $error("ir_cmd_mapper: illegal NUM_CMDS, TIMEOUT_CYCLES or HEARTBEAT_CYCLES");
    end

    localparam logic [31:0] ToLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HbLast = 32'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cmd_q, cmd_d;
    logic        timed_out_q, timed_out_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [31:0] hb_cnt_q, hb_cnt_d;
    logic [2:0]  seq_q, seq_d;
    logic        err_q, err_d;
    logic        evt_q, evt_d;
    logic        pending_q, pending_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_byte_q, tx_byte_d;

    logic        inv_ok;
    logic        frame_good;
    logic        frame_bad;
    logic        key_hit;
    logic [2:0]  key_idx;
    logic        timeout_evt;
    logic        hb_evt;
    logic        xfer;
    logic        unused_frame_low;

    assign unused_frame_low = ^bus.frame_data[15:0];

    assign inv_ok     = (bus.frame_data[31:24] == ~bus.frame_data[23:16]);
    assign frame_good = bus.frame_valid && inv_ok;
    assign frame_bad  = bus.frame_valid && !inv_ok;

    // Scan from the top entry down so the lowest matching index wins.
    always_comb begin
        key_hit = 1'b0;
        key_idx = 3'd0;
        for (int i = int'(NUM_CMDS) - 1; i >= 0; i--) begin
            if (bus.frame_data[23:16] == KEY_MAP[8*i +: 8]) begin
                key_hit = 1'b1;
                key_idx = 3'(i + 1);
            end
        end
    end

    // Command FSM: a good frame always outranks a repeat or the timeout expiry.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        timed_out_d = timed_out_q;
        to_cnt_d    = to_cnt_q;
        timeout_evt = 1'b0;

        if (frame_good) begin
            timed_out_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_good && key_hit) begin
                    state_d  = StActive;
                    cmd_d    = key_idx;
                    to_cnt_d = '0;
                end
            end
            StActive: begin
                if (frame_good) begin
                    to_cnt_d = '0;
                    if (key_hit) begin
                        cmd_d = key_idx;
                    end else begin
                        cmd_d   = 3'd0;
                        state_d = StIdle;
                    end
                end else if (bus.ir_repeat) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == ToLast) begin
                    state_d     = StIdle;
                    cmd_d       = 3'd0;
                    timed_out_d = 1'b1;
                    timeout_evt = 1'b1;
                    to_cnt_d    = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Events are registered so the snapshot sees the already-updated command state.
    always_comb begin
        hb_evt = (hb_cnt_q == HbLast);
        xfer   = tx_valid_q && bus.tx_ready;
        evt_d  = (cmd_d != cmd_q) || timeout_evt || frame_bad || hb_evt;

        hb_cnt_d = (xfer || hb_evt) ? 32'd0 : hb_cnt_q + 32'd1;
        seq_d    = xfer ? seq_q + 3'd1 : seq_q;
        err_d    = frame_bad || (err_q && !xfer);

        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        pending_d  = pending_q;

        if (tx_valid_q) begin
            if (evt_q) begin
                pending_d = 1'b1;
            end
            if (xfer) begin
                tx_valid_d = 1'b0;
            end
        end else if (evt_q || pending_q) begin
            tx_valid_d = 1'b1;
            tx_byte_d  = {cmd_q, timed_out_q, err_q, seq_q};
            pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_q       <= 3'd0;
            timed_out_q <= 1'b0;
            to_cnt_q    <= '0;
            hb_cnt_q    <= '0;
            seq_q       <= 3'd0;
            err_q       <= 1'b0;
            evt_q       <= 1'b0;
            pending_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            timed_out_q <= timed_out_d;
            to_cnt_q    <= to_cnt_d;
            hb_cnt_q    <= hb_cnt_d;
            seq_q       <= seq_d;
            err_q       <= err_d;
            evt_q       <= evt_d;
            pending_q   <= pending_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    assign bus.cmd_idx    = cmd_q;
    assign bus.cmd_onehot = 8'd1 << cmd_q;
    assign bus.timed_out  = timed_out_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_byte    = tx_byte_q;

endmodule
